// File: rtl/sos_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sos_pkg
// Purpose  : Shared constants, helpers and FSM state type for the SOS
//            coefficient loader (frame word layout, Q-format unity, states).
// Revision : 1.0 - initial release
// ============================================================================
package sos_pkg;

    // Position of each coefficient inside one section's six-word group
    localparam int unsigned IDX_B0        = 0;
    localparam int unsigned IDX_B1        = 1;
    localparam int unsigned IDX_B2        = 2;
    localparam int unsigned IDX_A0        = 3;
    localparam int unsigned IDX_A1        = 4;
    localparam int unsigned IDX_A2        = 5;
    localparam int unsigned WORDS_PER_SEC = 6;

    // Total words in one coefficient frame: six per section plus the gain
    function automatic int unsigned frame_len(input int unsigned n);
        return WORDS_PER_SEC * n + 1;
    endfunction

    // Word index of the global gain (always the final word of a frame)
    function automatic int unsigned gain_idx(input int unsigned n);
        return WORDS_PER_SEC * n;
    endfunction

    // Fixed-point 1.0 for a format with wf fraction bits
    function automatic int unsigned one_q(input int unsigned wf);
        return 32'd1 << wf;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sos_coeff_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : sos_coeff_loader_if
// Purpose  : Valid/ready coefficient word stream into the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface sos_coeff_loader_if #(
    parameter int LD_W = 16
);
    logic            ld_valid;
    logic            ld_ready;
    logic            ld_first;
    logic [LD_W-1:0] ld_data;

    modport master (output ld_valid, output ld_first, output ld_data, input ld_ready);
    modport slave  (input ld_valid, input ld_first, input ld_data, output ld_ready);
endinterface
`default_nettype wire

// File: rtl/sos_coeff_bank.sv
`default_nettype none
// ============================================================================
// Module   : sos_coeff_bank
// Purpose  : One bank of SOS coefficients. Single write port addressed by
//            frame word index, single combinational read port by section.
//            Resets to a passthrough filter (b0 = a0 = 1.0, gain = 1.0).
// Revision : 1.0 - initial release
// ============================================================================
module sos_coeff_bank
    import sos_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int WB           = 10,
    parameter int WA           = 10,
    parameter int WG           = 16,
    parameter int WF_B         = 8,
    parameter int WF_A         = 8,
    parameter int WF_G         = 11,
    parameter int LD_W         = 16,
    parameter int IDX_W        = 5,
    parameter int RS_W         = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_we,
    input  wire logic [IDX_W-1:0] i_widx,
    input  wire logic [LD_W-1:0]  i_wdata,
    input  wire logic [RS_W-1:0]  i_rsec,
    output logic      [WB-1:0]    o_b0,
    output logic      [WB-1:0]    o_b1,
    output logic      [WB-1:0]    o_b2,
    output logic      [WA-1:0]    o_a0,
    output logic      [WA-1:0]    o_a1,
    output logic      [WA-1:0]    o_a2,
    output logic      [WG-1:0]    o_gain
);

    localparam logic [WB-1:0] c_ONE_B = WB'(one_q(WF_B));
    localparam logic [WA-1:0] c_ONE_A = WA'(one_q(WF_A));
    localparam logic [WG-1:0] c_ONE_G = WG'(one_q(WF_G));

    logic [WB-1:0] r_b0 [NUM_SECTIONS];
    logic [WB-1:0] r_b1 [NUM_SECTIONS];
    logic [WB-1:0] r_b2 [NUM_SECTIONS];
    logic [WA-1:0] r_a0 [NUM_SECTIONS];
    logic [WA-1:0] r_a1 [NUM_SECTIONS];
    logic [WA-1:0] r_a2 [NUM_SECTIONS];
    logic [WG-1:0] r_gain;

    // Bits above the widest coefficient are intentionally dropped
    logic w_unused_wdata;
    assign w_unused_wdata = ^i_wdata;

    // Bank storage: passthrough on reset, otherwise decode the word index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                r_b0[s] <= c_ONE_B;
                r_b1[s] <= '0;
                r_b2[s] <= '0;
                r_a0[s] <= c_ONE_A;
                r_a1[s] <= '0;
                r_a2[s] <= '0;
            end
            r_gain <= c_ONE_G;
        end else if (i_we) begin
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                if (i_widx == IDX_W'(WORDS_PER_SEC * s + IDX_B0)) r_b0[s] <= i_wdata[WB-1:0];
                if (i_widx == IDX_W'(WORDS_PER_SEC * s + IDX_B1)) r_b1[s] <= i_wdata[WB-1:0];
                if (i_widx == IDX_W'(WORDS_PER_SEC * s + IDX_B2)) r_b2[s] <= i_wdata[WB-1:0];
                if (i_widx == IDX_W'(WORDS_PER_SEC * s + IDX_A0)) r_a0[s] <= i_wdata[WA-1:0];
                if (i_widx == IDX_W'(WORDS_PER_SEC * s + IDX_A1)) r_a1[s] <= i_wdata[WA-1:0];
                if (i_widx == IDX_W'(WORDS_PER_SEC * s + IDX_A2)) r_a2[s] <= i_wdata[WA-1:0];
            end
            if (i_widx == IDX_W'(gain_idx(NUM_SECTIONS))) r_gain <= i_wdata[WG-1:0];
        end
    end

    assign o_b0   = r_b0[i_rsec];
    assign o_b1   = r_b1[i_rsec];
    assign o_b2   = r_b2[i_rsec];
    assign o_a0   = r_a0[i_rsec];
    assign o_a1   = r_a1[i_rsec];
    assign o_a2   = r_a2[i_rsec];
    assign o_gain = r_gain;

endmodule
`default_nettype wire

// File: rtl/sos_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : sos_coeff_loader
// Purpose  : Double-buffered coefficient loader for a cascade of IIR SOS
//            sections. A frame is streamed into the shadow bank; the banks
//            swap only on a CE sample strobe so a section never mixes old
//            and new coefficients.
// Options  : SOS_COEFF_RANGE_CHECK_EN - reject frames containing words that
//            do not fit their coefficient width (sets err_range).
// Revision : 1.0 - initial release
// ============================================================================
module sos_coeff_loader
    import sos_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int WI_B         = 2,
    parameter int WF_B         = 8,
    parameter int WI_A         = 2,
    parameter int WF_A         = 8,
    parameter int WI_G         = 5,
    parameter int WF_G         = 11,
    parameter int LD_W         = WI_G + WF_G
) (
    input  wire logic                            CLK,
    input  wire logic                            Reset,
    input  wire logic                            CE,
    sos_coeff_loader_if.slave                    ld,
    input  wire logic [$clog2(NUM_SECTIONS)-1:0] rd_sec,
    output logic      [WI_B+WF_B-1:0]            rd_b0,
    output logic      [WI_B+WF_B-1:0]            rd_b1,
    output logic      [WI_B+WF_B-1:0]            rd_b2,
    output logic      [WI_A+WF_A-1:0]            rd_a0,
    output logic      [WI_A+WF_A-1:0]            rd_a1,
    output logic      [WI_A+WF_A-1:0]            rd_a2,
    output logic      [WI_G+WF_G-1:0]            gain_out,
    output logic                                 swap_done,
    output logic                                 busy,
    output logic                                 err_range,
    output logic                                 err_frame,
    input  wire logic                            err_clr
);

    localparam int WB        = WI_B + WF_B;
    localparam int WA        = WI_A + WF_A;
    localparam int WG        = WI_G + WF_G;
    localparam int FRAME_LEN = frame_len(NUM_SECTIONS);
    localparam int GAIN_IDX  = gain_idx(NUM_SECTIONS);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int RS_W      = $clog2(NUM_SECTIONS);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt, w_widx;
    logic [2:0]       r_k, w_k_nxt;
    logic             r_frame_bad, w_frame_bad_nxt;
    logic             r_bank_sel;
    logic             r_swap_done;
    logic             r_err_frame;
    logic             w_we, w_toggle, w_set_frame, w_set_range;
    logic             w_ready, w_accept, w_range_bad;
    logic             w_is_gain, w_is_b;
    logic [RS_W-1:0]  w_rsec;

    logic [WB-1:0] r_rd_b0, r_rd_b1, r_rd_b2;
    logic [WA-1:0] r_rd_a0, r_rd_a1, r_rd_a2;
    logic [WG-1:0] r_gain;

    logic [WB-1:0] w_bk_b0 [2];
    logic [WB-1:0] w_bk_b1 [2];
    logic [WB-1:0] w_bk_b2 [2];
    logic [WA-1:0] w_bk_a0 [2];
    logic [WA-1:0] w_bk_a1 [2];
    logic [WA-1:0] w_bk_a2 [2];
    logic [WG-1:0] w_bk_g  [2];

    // Stream is stalled while in reset and while a full frame awaits its swap
    assign w_ready     = !Reset && (r_state != PENDING);
    assign ld.ld_ready = w_ready;
    assign w_accept    = ld.ld_valid && w_ready;

    // A restart word is always b0; otherwise the phase counter selects the type
    assign w_is_gain = !ld.ld_first && (r_cnt == IDX_W'(GAIN_IDX));
    assign w_is_b    = ld.ld_first || (!w_is_gain && (r_k < 3'(IDX_A0)));

`ifdef SOS_COEFF_RANGE_CHECK_EN
    logic w_fit_b, w_fit_a, w_fit_g;
    logic r_err_range;
    // Word fits when every bit from the coefficient sign bit upward agrees
    assign w_fit_b     = (&ld.ld_data[LD_W-1:WB-1]) || !(|ld.ld_data[LD_W-1:WB-1]);
    assign w_fit_a     = (&ld.ld_data[LD_W-1:WA-1]) || !(|ld.ld_data[LD_W-1:WA-1]);
    assign w_fit_g     = (&ld.ld_data[LD_W-1:WG-1]) || !(|ld.ld_data[LD_W-1:WG-1]);
    assign w_range_bad = w_is_gain ? !w_fit_g : (w_is_b ? !w_fit_b : !w_fit_a);

    // Sticky range error; a new error in the clear cycle takes priority
    always_ff @(posedge CLK) begin
        if (Reset) r_err_range <= 1'b0;
        else       r_err_range <= w_set_range || (r_err_range && !err_clr);
    end
    assign err_range = r_err_range;
`else
    assign w_range_bad = 1'b0;
    assign err_range   = 1'b0;
`endif

    // Next-state, shadow-bank write and error-event decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_k_nxt         = r_k;
        w_frame_bad_nxt = r_frame_bad;
        w_widx          = r_cnt;
        w_we            = 1'b0;
        w_toggle        = 1'b0;
        w_set_frame     = 1'b0;
        w_set_range     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (ld.ld_first) begin
                        w_we            = 1'b1;
                        w_widx          = '0;
                        w_cnt_nxt       = IDX_W'(1);
                        w_k_nxt         = 3'd1;
                        w_frame_bad_nxt = w_range_bad;
                        w_set_range     = w_range_bad;
                        w_state_nxt     = LOAD;
                    end else begin
                        w_set_frame = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (w_accept) begin
                    w_we        = 1'b1;
                    w_set_range = w_range_bad;
                    if (ld.ld_first) begin
                        w_widx          = '0;
                        w_cnt_nxt       = IDX_W'(1);
                        w_k_nxt         = 3'd1;
                        w_frame_bad_nxt = w_range_bad;
                        w_set_frame     = 1'b1;
                    end else if (r_cnt == IDX_W'(FRAME_LEN - 1)) begin
                        w_cnt_nxt       = '0;
                        w_k_nxt         = 3'd0;
                        w_frame_bad_nxt = 1'b0;
                        w_state_nxt     = (r_frame_bad || w_range_bad) ? IDLE : PENDING;
                    end else begin
                        w_cnt_nxt       = r_cnt + 1'b1;
                        w_k_nxt         = (r_k == 3'd5) ? 3'd0 : r_k + 3'd1;
                        w_frame_bad_nxt = r_frame_bad || w_range_bad;
                    end
                end
            end
            PENDING: begin
                if (CE) begin
                    w_toggle    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, word counter, bank select and sticky frame error
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_k         <= 3'd0;
            r_frame_bad <= 1'b0;
            r_bank_sel  <= 1'b0;
            r_swap_done <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_k         <= w_k_nxt;
            r_frame_bad <= w_frame_bad_nxt;
            r_bank_sel  <= r_bank_sel ^ w_toggle;
            r_swap_done <= w_toggle;
            r_err_frame <= w_set_frame || (r_err_frame && !err_clr);
        end
    end

    // Sections beyond the configured count alias to section 0
    assign w_rsec = (int'(rd_sec) >= NUM_SECTIONS) ? '0 : rd_sec;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        sos_coeff_bank #(
            .NUM_SECTIONS (NUM_SECTIONS),
            .WB           (WB),
            .WA           (WA),
            .WG           (WG),
            .WF_B         (WF_B),
            .WF_A         (WF_A),
            .WF_G         (WF_G),
            .LD_W         (LD_W),
            .IDX_W        (IDX_W),
            .RS_W         (RS_W)
        ) u_bank (
            .clk     (CLK),
            .rst     (Reset),
            .i_we    (w_we && (r_bank_sel != 1'(gi))),
            .i_widx  (w_widx),
            .i_wdata (ld.ld_data),
            .i_rsec  (w_rsec),
            .o_b0    (w_bk_b0[gi]),
            .o_b1    (w_bk_b1[gi]),
            .o_b2    (w_bk_b2[gi]),
            .o_a0    (w_bk_a0[gi]),
            .o_a1    (w_bk_a1[gi]),
            .o_a2    (w_bk_a2[gi]),
            .o_gain  (w_bk_g[gi])
        );
    end

    // Registered read of the active bank; passthrough values out of reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_rd_b0 <= WB'(one_q(WF_B));
            r_rd_b1 <= '0;
            r_rd_b2 <= '0;
            r_rd_a0 <= WA'(one_q(WF_A));
            r_rd_a1 <= '0;
            r_rd_a2 <= '0;
            r_gain  <= WG'(one_q(WF_G));
        end else begin
            r_rd_b0 <= w_bk_b0[r_bank_sel];
            r_rd_b1 <= w_bk_b1[r_bank_sel];
            r_rd_b2 <= w_bk_b2[r_bank_sel];
            r_rd_a0 <= w_bk_a0[r_bank_sel];
            r_rd_a1 <= w_bk_a1[r_bank_sel];
            r_rd_a2 <= w_bk_a2[r_bank_sel];
            r_gain  <= w_bk_g[r_bank_sel];
        end
    end

    assign rd_b0     = r_rd_b0;
    assign rd_b1     = r_rd_b1;
    assign rd_b2     = r_rd_b2;
    assign rd_a0     = r_rd_a0;
    assign rd_a1     = r_rd_a1;
    assign rd_a2     = r_rd_a2;
    assign gain_out  = r_gain;
    assign swap_done = r_swap_done;
    assign busy      = (r_state != IDLE);
    assign err_frame = r_err_frame;

endmodule
`default_nettype wire

// File: tb/tb_sos_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sos_coeff_loader
// Purpose  : Self-checking bench for sos_coeff_loader. Read requests and
//            expected swaps are queued by the stimulus and checked by
//            independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sos_coeff_loader;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        CE = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  rd_sec = 2'd0;
    logic [9:0]  rd_b0, rd_b1, rd_b2, rd_a0, rd_a1, rd_a2;
    logic [15:0] gain_out;
    logic        swap_done, busy, err_range, err_frame;

    sos_coeff_loader_if #(.LD_W(16)) ld_if ();

    sos_coeff_loader dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .CE        (CE),
        .ld        (ld_if),
        .rd_sec    (rd_sec),
        .rd_b0     (rd_b0),
        .rd_b1     (rd_b1),
        .rd_b2     (rd_b2),
        .rd_a0     (rd_a0),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .gain_out  (gain_out),
        .swap_done (swap_done),
        .busy      (busy),
        .err_range (err_range),
        .err_frame (err_frame),
        .err_clr   (err_clr)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endfunction

    typedef struct packed {
        logic [1:0]  sec;
        logic [9:0]  b0, b1, b2, a0, a1, a2;
        logic [15:0] g;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      swap_q[$];
    rd_exp_t mon_e;
    logic    rd_req = 1'b0;
    logic    rd_req_q = 1'b0;

    logic [9:0]  m_c [4][6];
    logic [15:0] m_g;
    logic [15:0] fr [25];

    // Read monitor: one cycle after a request, compare against the queued value
    always @(posedge CLK) rd_req_q <= rd_req;

    always @(negedge CLK) begin
        if (rd_req_q) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=request expected=none");
            end else begin
                mon_e = rd_q.pop_front();
                chk($sformatf("rd_b0[%0d]", mon_e.sec), 32'(rd_b0), 32'(mon_e.b0));
                chk($sformatf("rd_b1[%0d]", mon_e.sec), 32'(rd_b1), 32'(mon_e.b1));
                chk($sformatf("rd_b2[%0d]", mon_e.sec), 32'(rd_b2), 32'(mon_e.b2));
                chk($sformatf("rd_a0[%0d]", mon_e.sec), 32'(rd_a0), 32'(mon_e.a0));
                chk($sformatf("rd_a1[%0d]", mon_e.sec), 32'(rd_a1), 32'(mon_e.a1));
                chk($sformatf("rd_a2[%0d]", mon_e.sec), 32'(rd_a2), 32'(mon_e.a2));
                chk($sformatf("gain_out[%0d]", mon_e.sec), 32'(gain_out), 32'(mon_e.g));
            end
        end
    end

    // Swap monitor: every swap_done pulse must match a queued expected cycle
    always @(negedge CLK) begin
        if (swap_done === 1'b1) begin
            if (swap_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL swap_done_unexpected actual=1 expected=0 cycle=%0d", cyc);
            end else begin
                chk("swap_done_cycle", 32'(cyc), 32'(swap_q.pop_front()));
            end
        end else if (swap_q.size() > 0 && swap_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL swap_done_missing actual=0 expected=1 at cycle=%0d", swap_q[0]);
            void'(swap_q.pop_front());
        end
    end

    task automatic set_passthrough();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 6; k++) m_c[s][k] = 10'h000;
            m_c[s][0] = 10'h100;
            m_c[s][3] = 10'h100;
        end
        m_g = 16'h0800;
    endtask

    task automatic model_from_frame();
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 6; k++) m_c[s][k] = fr[6*s+k][9:0];
        m_g = fr[24];
    endtask

    // b coefficients positive, a coefficients negative, all well inside range
    task automatic build_frame(input int seed);
        int v;
        for (int i = 0; i < 24; i++) begin
            v = seed * 32 + i + 1;
            fr[i] = ((i % 6) >= 3) ? 16'(-v) : 16'(v);
        end
        fr[24] = 16'h0100 + 16'(seed);
    endtask

    task automatic send(input logic [15:0] d, input logic f);
        int n = 0;
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = d;
        ld_if.ld_first = f;
        #1;
        while (ld_if.ld_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL ld_ready_timeout actual=0 expected=1");
        end
        @(negedge CLK);
        ld_if.ld_valid = 1'b0;
        ld_if.ld_first = 1'b0;
    endtask

    task automatic send_frame(input int lo, input int hi, input logic first_on_lo);
        for (int i = lo; i <= hi; i++) send(fr[i], first_on_lo && (i == lo));
    endtask

    task automatic read_sec(input int s);
        rd_exp_t e;
        e.sec = 2'(s);
        e.b0 = m_c[s][0]; e.b1 = m_c[s][1]; e.b2 = m_c[s][2];
        e.a0 = m_c[s][3]; e.a1 = m_c[s][4]; e.a2 = m_c[s][5];
        e.g  = m_g;
        rd_sec = 2'(s);
        rd_req = 1'b1;
        rd_q.push_back(e);
        @(negedge CLK);
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int s = 0; s < 4; s++) read_sec(s);
    endtask

    task automatic pulse_ce(input bit expect_swap);
        CE = 1'b1;
        if (expect_swap) swap_q.push_back(cyc + 1);
        @(negedge CLK);
        CE = 1'b0;
    endtask

    initial begin
        repeat (20000) @(posedge CLK);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        ld_if.ld_valid = 1'b0;
        ld_if.ld_first = 1'b0;
        ld_if.ld_data  = 16'h0000;

        // Reset: stream stalled during reset, passthrough afterwards
        repeat (3) @(negedge CLK);
        chk("ld_ready_in_reset", 32'(ld_if.ld_ready), 32'd0);
        Reset = 1'b0;
        @(negedge CLK);
        chk("ld_ready_after_reset", 32'(ld_if.ld_ready), 32'd1);
        chk("busy_after_reset", 32'(busy), 32'd0);
        chk("err_frame_after_reset", 32'(err_frame), 32'd0);
        chk("err_range_after_reset", 32'(err_range), 32'd0);
        chk("swap_done_after_reset", 32'(swap_done), 32'd0);
        set_passthrough();
        read_all();

        // Full frame, CE low: active bank unchanged until the strobe
        build_frame(1);
        fr[13] = 16'h0080;
        send_frame(0, 24, 1'b1);
        chk("busy_pending", 32'(busy), 32'd1);
        chk("ld_ready_pending", 32'(ld_if.ld_ready), 32'd0);
        read_all();
        repeat (3) @(negedge CLK);
        chk("busy_still_pending", 32'(busy), 32'd1);
        pulse_ce(1'b1);
        model_from_frame();
        read_all();
        chk("busy_after_swap", 32'(busy), 32'd0);

        // Mid-frame restart at word 10
        for (int i = 0; i < 10; i++) send(16'h0033 + 16'(i), i == 0);
        chk("err_frame_before_restart", 32'(err_frame), 32'd0);
        build_frame(2);
        send(fr[0], 1'b1);
        chk("err_frame_on_restart", 32'(err_frame), 32'd1);
        send_frame(1, 24, 1'b0);
        chk("busy_restart_pending", 32'(busy), 32'd1);
        pulse_ce(1'b1);
        model_from_frame();
        read_all();
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        chk("err_frame_cleared", 32'(err_frame), 32'd0);
        // Stray word in IDLE while clearing: the set wins
        err_clr = 1'b1;
        send(16'h0001, 1'b0);
        err_clr = 1'b0;
        chk("err_frame_set_wins", 32'(err_frame), 32'd1);
        chk("busy_stray_word", 32'(busy), 32'd0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        chk("err_frame_cleared2", 32'(err_frame), 32'd0);

        // Out-of-range word 3 (a0 of section 0)
        build_frame(3);
        fr[3] = 16'h0400;
        send_frame(0, 24, 1'b1);
`ifdef SOS_COEFF_RANGE_CHECK_EN
        chk("err_range_set", 32'(err_range), 32'd1);
        chk("busy_range_discard", 32'(busy), 32'd0);
        pulse_ce(1'b0);
        read_all();
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        chk("err_range_cleared", 32'(err_range), 32'd0);
`else
        chk("err_range_tied", 32'(err_range), 32'd0);
        chk("busy_truncated_frame", 32'(busy), 32'd1);
        pulse_ce(1'b1);
        model_from_frame();
        read_all();
`endif

        // Last word accepted together with CE: swap deferred to next CE
        build_frame(0);
        send_frame(0, 23, 1'b1);
        CE = 1'b1;
        send(fr[24], 1'b0);
        CE = 1'b0;
        chk("busy_after_last_with_ce", 32'(busy), 32'd1);
        read_all();
        repeat (2) @(negedge CLK);
        pulse_ce(1'b1);
        model_from_frame();
        read_all();

        // Reset while PENDING discards everything
        build_frame(2);
        fr[0] = 16'h0055;
        send_frame(0, 24, 1'b1);
        chk("busy_before_reset", 32'(busy), 32'd1);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("busy_after_pending_reset", 32'(busy), 32'd0);
        chk("ld_ready_after_pending_reset", 32'(ld_if.ld_ready), 32'd1);
        set_passthrough();
        read_all();
        pulse_ce(1'b0);
        @(negedge CLK);
        chk("busy_after_ce_post_reset", 32'(busy), 32'd0);
        read_sec(0);

        repeat (3) @(negedge CLK);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("swap_queue_drained", 32'(swap_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
